// File: rtl/gauss_filter_5x5_if.sv
// gauss_filter_5x5_if: window-in / pixel-out bundle for the 5x5 Gaussian stage (bypass port exists only with GAUSS_BYPASS_EN)
interface gauss_filter_5x5_if;
  logic         in_valid;
  logic [199:0] win;
`ifdef GAUSS_BYPASS_EN
  logic         bypass;
`endif
  logic         out_valid;
  logic [7:0]   out_pixel;
  logic         out_eol;
  logic         out_eof;
  modport master (
    output
`ifdef GAUSS_BYPASS_EN
      bypass,
`endif
      in_valid, win,
    input out_valid, out_pixel, out_eol, out_eof
  );
  modport slave (
    input
`ifdef GAUSS_BYPASS_EN
      bypass,
`endif
      in_valid, win,
    output out_valid, out_pixel, out_eol, out_eof
  );
endinterface

// File: rtl/gauss_filter_5x5.sv
// gauss_filter_5x5: 4-stage pipelined 5x5 Gaussian smoother with row/frame flags; GAUSS_BYPASS_EN adds a per-window centre-pixel bypass
module gauss_filter_5x5 #(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512
) (
  input logic clk,
  input logic rst,
  gauss_filter_5x5_if.slave bus
);
  localparam int OUT_WIDTH  = IMAGE_WIDTH - 4;
  localparam int OUT_HEIGHT = IMAGE_HEIGHT - 4;
  localparam int CW = $clog2(OUT_WIDTH + 1);
  localparam int RW = $clog2(OUT_HEIGHT + 1);
  localparam logic [3:0] COEF [25] = '{
    4'd2, 4'd4,  4'd5,  4'd4,  4'd2,
    4'd4, 4'd9,  4'd12, 4'd9,  4'd4,
    4'd5, 4'd12, 4'd15, 4'd12, 4'd5,
    4'd4, 4'd9,  4'd12, 4'd9,  4'd4,
    4'd2, 4'd4,  4'd5,  4'd4,  4'd2
  };

  // The kernel only uses a handful of coefficients, so shift-add keeps multipliers out of the datapath
  function automatic logic [11:0] cmul(input logic [7:0] p, input logic [3:0] c);
    logic [11:0] x;
    x = {4'd0, p};
    return c == 4'd2  ? x << 1 :
           c == 4'd4  ? x << 2 :
           c == 4'd5  ? (x << 2) + x :
           c == 4'd9  ? (x << 3) + x :
           c == 4'd12 ? (x << 3) + (x << 2) :
                        (x << 4) - x;
  endfunction

  logic        byp_in;
  logic [11:0] p1 [25];
  logic [13:0] r2 [5];
  logic [15:0] s3;
  logic [23:0] scaled;
  logic [7:0]  c1, c2, c3, px4;
  logic        b1, b2, b3;
  logic        v1, v2, v3, v4;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic        last_col, last_row;

`ifdef GAUSS_BYPASS_EN
  assign byp_in = bus.bypass;
`else
  assign byp_in = 1'b0;
`endif

  // S1: coefficient products, plus the centre pixel and bypass choice travelling alongside
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= 1'b0;
      c1 <= '0;
      b1 <= 1'b0;
      for (int k = 0; k < 25; k++) p1[k] <= '0;
    end else begin
      v1 <= bus.in_valid;
      c1 <= bus.win[103:96];
      b1 <= byp_in;
      for (int k = 0; k < 25; k++) p1[k] <= cmul(bus.win[8*k +: 8], COEF[k]);
    end

  // S2: one partial sum per kernel row
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v2 <= 1'b0;
      c2 <= '0;
      b2 <= 1'b0;
      for (int j = 0; j < 5; j++) r2[j] <= '0;
    end else begin
      v2 <= v1;
      c2 <= c1;
      b2 <= b1;
      for (int j = 0; j < 5; j++)
        r2[j] <= 14'(p1[5*j]) + 14'(p1[5*j+1]) + 14'(p1[5*j+2]) + 14'(p1[5*j+3]) + 14'(p1[5*j+4]);
    end

  // S3: full weighted sum, at most 255*159
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v3 <= 1'b0;
      c3 <= '0;
      b3 <= 1'b0;
      s3 <= '0;
    end else begin
      v3 <= v2;
      c3 <= c2;
      b3 <= b2;
      s3 <= 16'(r2[0]) + 16'(r2[1]) + 16'(r2[2]) + 16'(r2[3]) + 16'(r2[4]);
    end

  // Divide by 159 as a rounded multiply by 103/16384
  assign scaled = (24'(s3) * 24'd103 + 24'd8192) >> 14;

  // S4: normalise and saturate, or pass the centre pixel through when bypassed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v4  <= 1'b0;
      px4 <= '0;
    end else begin
      v4  <= v3;
      px4 <= b3 ? c3 : (|scaled[23:8] ? 8'hFF : scaled[7:0]);
    end

  assign last_col = col == CW'(OUT_WIDTH - 1);
  assign last_row = row == RW'(OUT_HEIGHT - 1);

  // Output register and raster position tracking; flags only ever accompany a valid pixel
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_pixel <= '0;
      bus.out_eol   <= 1'b0;
      bus.out_eof   <= 1'b0;
      col <= '0;
      row <= '0;
    end else begin
      bus.out_valid <= v4;
      bus.out_pixel <= px4;
      bus.out_eol   <= v4 && last_col;
      bus.out_eof   <= v4 && last_col && last_row;
      if (v4) begin
        col <= last_col ? '0 : col + CW'(1);
        if (last_col) row <= last_row ? '0 : row + RW'(1);
      end
    end
endmodule

// File: tb/tb_gauss_filter_5x5.sv
// tb_gauss_filter_5x5: directed vectors, boundary sequences and random windows against a kernel-level reference model
module tb_gauss_filter_5x5;
  localparam int IW = 8, IH = 6, OW = IW - 4, OH = IH - 4;

  logic clk = 1'b0, rst = 1'b1, byp = 1'b0;
  always #5 clk = ~clk;

  gauss_filter_5x5_if bus_i ();
`ifdef GAUSS_BYPASS_EN
  assign bus_i.bypass = byp;
`endif

  gauss_filter_5x5 #(.IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)) dut (.clk(clk), .rst(rst), .bus(bus_i));

  typedef struct { int due; int pix; logic eol; logic eof; } exp_t;
  typedef struct { string name; logic [199:0] w; int e; } vec_t;

  int K [5][5] = '{'{2,4,5,4,2}, '{4,9,12,9,4}, '{5,12,15,12,5}, '{4,9,12,9,4}, '{2,4,5,4,2}};
  exp_t q[$];
  logic [1:0] obs[$];
  int opx[$];
  int checks = 0, errors = 0, cyc = 0, mcol = 0, mrow = 0;

  function automatic int ref_pix(logic [199:0] w, logic b);
    int s, n;
    if (b) return int'(w[103:96]);
    s = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) s += K[r][c] * int'(w[8*(5*r+c) +: 8]);
    n = (s * 103 + 8192) / 16384;
    return n > 255 ? 255 : n;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  // Expectation generator: every accepted window yields one output four edges later at the next raster position
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst && bus_i.in_valid) begin
      e.due = cyc + 4;
      e.pix = ref_pix(bus_i.win, byp);
      e.eol = mcol == OW - 1;
      e.eof = e.eol && mrow == OH - 1;
      mcol = e.eol ? 0 : mcol + 1;
      mrow = e.eof ? 0 : e.eol ? mrow + 1 : mrow;
      q.push_back(e);
    end
  end

  // Cycle-by-cycle scoreboard on the falling edge
  always @(negedge clk) begin
    if (rst)
      chk("reset_outputs", int'({bus_i.out_valid, bus_i.out_eol, bus_i.out_eof, bus_i.out_pixel}), 0);
    else if (q.size() != 0 && q[0].due == cyc) begin
      chk("out_valid", int'(bus_i.out_valid), 1);
      chk("out_pixel", int'(bus_i.out_pixel), q[0].pix);
      chk("out_eol", int'(bus_i.out_eol), int'(q[0].eol));
      chk("out_eof", int'(bus_i.out_eof), int'(q[0].eof));
      void'(q.pop_front());
    end else begin
      chk("idle_valid", int'(bus_i.out_valid), 0);
      chk("idle_flags", int'({bus_i.out_eol, bus_i.out_eof}), 0);
    end
    if (!rst && bus_i.out_valid) begin
      obs.push_back({bus_i.out_eol, bus_i.out_eof});
      opx.push_back(int'(bus_i.out_pixel));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [199:0] w, logic v);
    bus_i.win = w;
    bus_i.in_valid = v;
    step();
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    q.delete();
    mcol = 0;
    mrow = 0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  function automatic logic [199:0] rand_win();
    logic [199:0] w;
    for (int k = 0; k < 25; k++) w[8*k +: 8] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  initial begin
    vec_t vt[5];
    logic [199:0] w;
    int pat[12] = '{1,0,1,1,0,0,1,1,1,0,1,1};
    bus_i.in_valid = 1'b0;
    bus_i.win = '0;
    vt[0].name = "uniform100"; vt[0].w = {25{8'd100}}; vt[0].e = 100;
    vt[1].name = "all255";     vt[1].w = {25{8'd255}}; vt[1].e = 255;
    vt[2].name = "all0";       vt[2].w = '0;           vt[2].e = 0;
    w = '0; w[103:96] = 8'hFF;
    vt[3].name = "centre";     vt[3].w = w;            vt[3].e = 24;
    w = '0; w[7:0] = 8'hFF;
    vt[4].name = "corner";     vt[4].w = w;            vt[4].e = 3;

    repeat (3) step();
    do_reset(1);
    step();

    foreach (vt[i]) begin
      send(vt[i].w, 1'b1);
      send('0, 1'b0);
      step();
      step();
      chk({vt[i].name, "_early"}, int'(bus_i.out_valid), 0);
      step();
      chk({vt[i].name, "_valid"}, int'(bus_i.out_valid), 1);
      chk({vt[i].name, "_pixel"}, int'(bus_i.out_pixel), vt[i].e);
      step();
      chk({vt[i].name, "_single"}, int'(bus_i.out_valid), 0);
    end

    do_reset(2);
    obs.delete();
    foreach (pat[i]) send(rand_win(), pat[i] != 0);
    send(rand_win(), 1'b1);
    repeat (8) send('0, 1'b0);
    chk("gap_count", obs.size(), 9);
    if (obs.size() == 9) begin
      for (int i = 0; i < 9; i++) begin
        chk("gap_eol", int'(obs[i][1]), int'(i == 3 || i == 7));
        chk("gap_eof", int'(obs[i][0]), int'(i == 7));
      end
    end

    repeat (3) send(rand_win(), 1'b1);
    repeat (2) send('0, 1'b0);
    rst = 1'b1;
    q.delete();
    mcol = 0;
    mrow = 0;
    #1;
    chk("rst_async_clear", int'({bus_i.out_valid, bus_i.out_eol, bus_i.out_eof, bus_i.out_pixel}), 0);
    step();
    step();
    rst = 1'b0;
    obs.delete();
    repeat (4) send(rand_win(), 1'b1);
    repeat (6) send('0, 1'b0);
    chk("post_rst_count", obs.size(), 4);
    if (obs.size() == 4) chk("post_rst_eol", int'({obs[0][1], obs[1][1], obs[2][1], obs[3][1]}), 1);

`ifdef GAUSS_BYPASS_EN
    do_reset(1);
    opx.delete();
    w = '0; w[103:96] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      byp = (i % 2) == 0;
      send(w, 1'b1);
    end
    byp = 1'b0;
    repeat (6) send('0, 1'b0);
    chk("byp_count", opx.size(), 4);
    if (opx.size() == 4)
      for (int i = 0; i < 4; i++) chk("byp_pixel", opx[i], (i % 2) == 0 ? 255 : 24);
`endif

    for (int i = 0; i < 300; i++) begin
`ifdef GAUSS_BYPASS_EN
      byp = $urandom_range(0, 3) == 0;
`endif
      w = $urandom_range(0, 9) == 0 ? {25{8'hFF}} : rand_win();
      send(w, $urandom_range(0, 9) < 7);
    end
    byp = 1'b0;
    repeat (8) send('0, 1'b0);
    chk("drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
